// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch queue and its entry FIFO.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_1180;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, ins} entries.
// Synchronous clear drops everything at once on a redirect.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          pop_ok;

  assign pop_ok = pop && (count != '0);
  assign head   = mem[rp];

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: credit-limited requests,
// in-order response queue, redirect flush with stale drop.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_npc,
  output logic [ILEN-1:0] id_ins
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pwp;
  logic [AW-1:0]   prp;
  logic            accept;
  logic            keep;
  logic            pop;
  fetch_entry_t    din;
  fetch_entry_t    head;

  assign used = {1'b0, inflight} + {1'b0, count};

  assign imem_req_valid = !rst && !redirect_valid
                       && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;

  assign keep = imem_rsp_valid && !redirect_valid
             && (drop_cnt == '0);
  assign din  = '{pc: pcq[prp], ins: imem_rsp_data};

  assign id_valid = !rst && (count != '0);
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign id_pc    = head.pc;
  assign id_ins   = head.ins;
  assign id_npc   = head.pc + XLEN'(PC_STEP);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (keep),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // address of every accepted request, in issue order
  always_ff @(posedge clk) begin
    if (accept) pcq[pwp] <= fetch_pc;
  end

  // fetch pointer, credit and stale-response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      pwp      <= '0;
      prp      <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
      if (accept)         pwp <= pwp + 1'b1;
      if (imem_rsp_valid) prp <= prp + 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        drop_cnt <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (imem_rsp_valid && drop_cnt != '0)
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // protocol sanity on the memory side and the credit limit
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && inflight == '0))
        else $error("rsp_valid with nothing in flight");
      assert (used <= (CW+1)'(DEPTH))
        else $error("credit overflow");
    end
  end
`endif

endmodule
